// File: rtl/mac_dot_sequencer_pkg.sv
// Shared types and defaults for the MAC dot-product sequencer.
// Holds the FSM state encoding, width defaults and the wait-counter width helper.
package mac_dot_sequencer_pkg;

    localparam int DEF_A_W     = 18;
    localparam int DEF_P_W     = 48;
    localparam int DEF_LEN_W   = 10;
    localparam int DEF_MAC_LAT = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Wait counter must hold MAC_LAT; keep at least one bit when MAC_LAT is 0.
    function automatic int cnt_w(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/mac_dot_sequencer.sv
// Sequences an external p = a*b + c MAC core to form signed dot products.
// Ports: clock/reset; start/len job request; busy; in_valid/in_ready/in_a/in_b
// operand stream; mac_a/mac_b/mac_c to core, mac_p from core;
// out_valid/out_ready/out_result result stream.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int A_W     = DEF_A_W,
    parameter int P_W     = DEF_P_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [A_W-1:0]   in_b,
    output logic [A_W-1:0]   mac_a,
    output logic [A_W-1:0]   mac_b,
    output logic [P_W-1:0]   mac_c,
    input  logic [P_W-1:0]   mac_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   out_result
);

    localparam int CW = cnt_w(MAC_LAT);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_remaining;
    logic [CW-1:0]    r_wait;
    logic [P_W-1:0]   r_acc;
    logic             w_last;

    assign w_last = (r_remaining == LEN_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake outputs are pure decodes of state so reset clears them at once.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait == '0) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The core's p is only trusted on the edge where r_wait has run down to
    // zero: MAC_LAT+1 edges after the operands were registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
            r_wait      <= '0;
            r_acc       <= '0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_c       <= '0;
            out_result  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= len;
                        r_acc       <= '0;
                        if (len == '0) begin
                            out_result <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        mac_a  <= in_a;
                        mac_b  <= in_b;
                        mac_c  <= r_acc;
                        r_wait <= CW'(MAC_LAT);
                    end
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_acc       <= mac_p;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last) begin
                            out_result <= mac_p;
                        end
                    end else begin
                        r_wait <= r_wait - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a pipelined p = a*b + c core model.
// Operand pairs stream from a queue; results are checked against hand values.
module tb_mac_dot_sequencer;

    localparam int A_W     = 18;
    localparam int P_W     = 48;
    localparam int LEN_W   = 10;
    localparam int MAC_LAT = 3;
    localparam int TMO     = 300;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [A_W-1:0]   in_b;
    logic [A_W-1:0]   mac_a;
    logic [A_W-1:0]   mac_b;
    logic [P_W-1:0]   mac_c;
    logic [P_W-1:0]   mac_p;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   out_result;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int stall   = 0;
    int cyc;
    int base;
    bit saw_ready;

    logic [A_W-1:0] qa[$];
    logic [A_W-1:0] qb[$];

    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] pipe [MAC_LAT];

    mac_dot_sequencer #(
        .A_W     (A_W),
        .P_W     (P_W),
        .LEN_W   (LEN_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_p      (mac_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clock = ~clock;

    assign w_prod = P_W'($signed(mac_a)) * P_W'($signed(mac_b))
                  + $signed(mac_c);

    always @(posedge clock) begin
        pipe[0] <= w_prod;
        for (int i = 1; i < MAC_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign mac_p = pipe[MAC_LAT-1];

    always @(posedge clock) begin
        if (in_ready) begin
            saw_ready <= 1'b1;
        end
        if (!reset && in_valid && in_ready && qa.size() > 0) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            n_acc <= n_acc + 1;
        end
    end

    initial begin
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        forever begin
            @(negedge clock);
            if (stall > 0) begin
                in_valid = 1'b0;
                stall    = stall - 1;
            end else if (qa.size() > 0) begin
                in_valid = 1'b1;
                in_a     = qa[0];
                in_b     = qb[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int b);
        qa.push_back(A_W'(a));
        qb.push_back(A_W'(b));
    endtask

    task automatic do_start(input int l);
        @(negedge clock);
        start = 1'b1;
        len   = LEN_W'(l);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 1;
        while (!out_valid && c < TMO) begin
            @(negedge clock);
            c++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (n_acc < n && k < TMO) begin
            @(negedge clock);
            k++;
        end
        if (n_acc < n) check("accept_timeout", n_acc, n);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, out_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_c", mac_c, 0);
        check("rst_result", out_result, 0);
        reset = 1'b0;

        // Basic job and latency from start to out_valid.
        push(2, 3); push(4, 5); push(-1, 7);
        base = n_acc;
        do_start(3);
        wait_valid(cyc);
        check("basic_latency", cyc, 3 * (MAC_LAT + 2) + 1);
        check("basic_result", $signed(out_result), 19);
        check("basic_terms", n_acc - base, 3);
        take_result("basic");

        // Zero-length job.
        saw_ready = 1'b0;
        do_start(0);
        check("len0_valid", out_valid, 1);
        check("len0_result", out_result, 0);
        take_result("len0");
        check("len0_no_ready", saw_ready, 0);

        // Extreme operands.
        push(131071, 131071); push(131071, 131071);
        do_start(2);
        wait_valid(cyc);
        check("maxpos_result", $signed(out_result), 64'sd34359214082);
        take_result("maxpos");
        push(-131072, 131071);
        do_start(1);
        wait_valid(cyc);
        check("maxneg_result", $signed(out_result), -64'sd17179738112);
        take_result("maxneg");

        // Input stall mid-job and delayed result accept.
        push(1, 2); push(3, 4); push(5, 6);
        base = n_acc;
        do_start(3);
        wait_acc(base + 1);
        stall = 9;
        check("stall_mac_a_hold", mac_a, 1);
        wait_valid(cyc);
        repeat (4) @(negedge clock);
        check("stall_vld_held", out_valid, 1);
        check("stall_result", $signed(out_result), 44);
        check("stall_terms", n_acc - base, 3);
        take_result("stall");

        // Reset during WAIT of term 2.
        push(1, 1); push(2, 2); push(3, 3); push(4, 4);
        base = n_acc;
        do_start(4);
        wait_acc(base + 2);
        @(negedge clock);
        check("mid_busy", busy, 1);
        check("mid_in_ready", in_ready, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mac_a", mac_a, 0);
        check("arst_mac_b", mac_b, 0);
        check("arst_mac_c", mac_c, 0);
        check("arst_result", out_result, 0);
        check("arst_out_valid", out_valid, 0);
        qa.delete();
        qb.delete();
        @(negedge clock);
        reset = 1'b0;
        push(3, 3);
        do_start(1);
        wait_valid(cyc);
        check("post_rst_result", $signed(out_result), 9);
        take_result("post_rst");

        // Start while busy must be ignored.
        push(2, 2); push(3, 3); push(5, 5); push(7, 7);
        base = n_acc;
        do_start(2);
        repeat (2) @(negedge clock);
        start = 1'b1;
        len   = LEN_W'(4);
        @(negedge clock);
        start = 1'b0;
        wait_valid(cyc);
        check("ign_result", $signed(out_result), 13);
        check("ign_terms", n_acc - base, 2);
        take_result("ign");
        repeat (3) @(negedge clock);
        check("ign_stays_idle", busy, 0);
        check("ign_leftover", qa.size(), 2);
        qa.delete();
        qb.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
